time_set_controller: RTL

TIME_SET_CONTROLLER -- requirements
Module: time_set_controller

---
 rtl/time_set_controller.sv | 139 +++++++++++++
 1 files changed

// File: rtl/time_set_controller.sv
// time_set_controller: debounced two-key clock time editor (RUN -> SET_HOUR -> SET_MIN -> COMMIT).
// Optional AUTO_REPEAT_EN adds hold-to-repeat on key_inc while editing.
module time_set_controller #(
  parameter int CLK_HZ          = 50000000,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic       clock_in,
  input  logic       reset,
  input  logic       key_mode,
  input  logic       key_inc,
  input  logic [4:0] cur_hour,
  input  logic [5:0] cur_min,
  output logic       run_en,
  output logic       load,
  output logic [4:0] set_hour,
  output logic [5:0] set_min,
  output logic [5:0] blink_mask,
  output logic [1:0] mode
);
  typedef enum logic [1:0] {RUN = 2'd0, SET_HOUR = 2'd1, SET_MIN = 2'd2, COMMIT = 2'd3} state_t;
  localparam logic [31:0] DB_LAST    = 32'(DEBOUNCE_CYCLES - 1);
  localparam logic [31:0] BLINK_LAST = 32'(CLK_HZ / 4 - 1);
  state_t      state_q, state_d;
  logic [1:0]  s1_q, s2_q, stable_q, stable_d, prev_q;
  logic [31:0] db_q [2];
  logic [31:0] db_d [2];
  logic [31:0] blink_cnt_q, blink_cnt_d;
  logic        phase_q, phase_d, run_en_q, run_en_d, load_q, load_d;
  logic [4:0]  set_hour_q, set_hour_d;
  logic [5:0]  set_min_q, set_min_d, mask_q, mask_d;
  logic        mode_ev, inc_press, inc_ev;
  always_comb begin
    stable_d = stable_q;
    for (int k = 0; k < 2; k++) begin
      db_d[k] = '0;
      if (s2_q[k] != stable_q[k]) begin
        if (db_q[k] == DB_LAST) stable_d[k] = s2_q[k];
        else db_d[k] = db_q[k] + 32'd1;
      end
    end
  end
  // bit 0 = mode key, bit 1 = inc key; events fire on the stable 1->0 edge only
  assign mode_ev   = prev_q[0] & ~stable_q[0];
  assign inc_press = prev_q[1] & ~stable_q[1];
`ifdef AUTO_REPEAT_EN
  logic [31:0] rep_q, rep_d;
  logic        first_q, first_d, rep_fire;
  always_comb begin
    rep_d    = '0;
    first_d  = first_q;
    rep_fire = 1'b0;
    if (inc_press) first_d = 1'b1;
    else if (!stable_q[1] && (state_q == SET_HOUR || state_q == SET_MIN)) begin
      if (rep_q == (first_q ? 32'(CLK_HZ / 2 - 1) : 32'(CLK_HZ / 8 - 1))) begin
        rep_fire = 1'b1;
        first_d  = 1'b0;
      end else rep_d = rep_q + 32'd1;
    end
  end
  always_ff @(posedge clock_in or negedge reset)
    if (!reset) begin
      rep_q   <= '0;
      first_q <= 1'b1;
    end else begin
      rep_q   <= rep_d;
      first_q <= first_d;
    end
  assign inc_ev = inc_press | rep_fire;
`else
  assign inc_ev = inc_press;
`endif
  always_comb begin
    state_d    = state_q;
    set_hour_d = set_hour_q;
    set_min_d  = set_min_q;
    run_en_d   = run_en_q;
    load_d     = 1'b0;
    case (state_q)
      RUN: if (mode_ev) begin
        state_d    = SET_HOUR;
        set_hour_d = cur_hour;
        set_min_d  = cur_min;
        run_en_d   = 1'b0;
      end
      SET_HOUR: if (mode_ev) state_d = SET_MIN;
        else if (inc_ev) set_hour_d = (set_hour_q == 5'd23) ? 5'd0 : set_hour_q + 5'd1;
      SET_MIN: if (mode_ev) begin
        state_d = COMMIT;
        load_d  = 1'b1;
      end else if (inc_ev) set_min_d = (set_min_q == 6'd59) ? 6'd0 : set_min_q + 6'd1;
      default: begin
        state_d  = RUN;
        run_en_d = 1'b1;
      end
    endcase
    blink_cnt_d = (state_d != state_q || blink_cnt_q == BLINK_LAST) ? '0 : blink_cnt_q + 32'd1;
    phase_d     = (state_d != state_q) ? 1'b0 : (blink_cnt_q == BLINK_LAST) ? ~phase_q : phase_q;
    mask_d      = !phase_d ? 6'd0 : (state_d == SET_HOUR) ? 6'b110000 :
                  (state_d == SET_MIN) ? 6'b001100 : 6'd0;
  end
  always_ff @(posedge clock_in or negedge reset)
    if (!reset) begin
      s1_q        <= 2'b11;
      s2_q        <= 2'b11;
      stable_q    <= 2'b11;
      prev_q      <= 2'b11;
      db_q[0]     <= '0;
      db_q[1]     <= '0;
      state_q     <= RUN;
      set_hour_q  <= '0;
      set_min_q   <= '0;
      run_en_q    <= 1'b1;
      load_q      <= 1'b0;
      blink_cnt_q <= '0;
      phase_q     <= 1'b0;
      mask_q      <= '0;
    end else begin
      s1_q        <= {key_inc, key_mode};
      s2_q        <= s1_q;
      stable_q    <= stable_d;
      prev_q      <= stable_q;
      db_q[0]     <= db_d[0];
      db_q[1]     <= db_d[1];
      state_q     <= state_d;
      set_hour_q  <= set_hour_d;
      set_min_q   <= set_min_d;
      run_en_q    <= run_en_d;
      load_q      <= load_d;
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
      mask_q      <= mask_d;
    end
  assign run_en     = run_en_q;
  assign load       = load_q;
  assign set_hour   = set_hour_q;
  assign set_min    = set_min_q;
  assign blink_mask = mask_q;
  assign mode       = state_q;
endmodule
